fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin arbiter sharing the write port of one `fifo` instance between `NUM_REQ` producers. Arbitration is packet-based: a producer holds the write port from its first word until it transfers a word flagged `last`, so packets never interleave in the FIFO. It sits between producer blocks (UART RX, SPI, debug taps) and a shared FIFO. It drives the FIFO's `write`/`write_data` and observes its `can_write`.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be at least 2.
- `BIT_WIDTH`, default 8: word width; must equal the FIFO's `bit_width`.
- `ID_W`, derived as `$clog2(NUM_REQ)`: grant index width. This is a localparam, not overridable.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `req_valid`, in, NUM_REQ: bit i is set when requester i has a word on its data lane.
- `req_last`, in, NUM_REQ: bit i marks the current word of requester i as the final word of its packet.
- `req_data`, in, NUM_REQ*BIT_WIDTH: requester i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
- `req_ready`, out, NUM_REQ: bit i is set when the arbiter accepts requester i's word this cycle.
- `fifo_write`, out, 1: connects to the FIFO `write` input.
- `fifo_write_data`, out, BIT_WIDTH: connects to the FIFO `write_data` input.
- `fifo_can_write`, in, 1: from the FIFO `can_write` output.
- `grant_id`, out, ID_W: index of the current owner; 0 when idle.
- `busy`, out, 1: high while a packet owns the port.

## Operation
- **Transfer rule.** A word for requester i transfers on any cycle where `req_valid[i] && req_ready[i]`. The FIFO sees exactly one write on each such cycle.
- **State `IDLE`:**
  - `req_ready`, `fifo_write`, `busy` and `fifo_write_data` are all 0.
  - If any `req_valid` bit is set, select the winner: the first set bit scanning upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - Register the winner as `owner` and go to `LOCKED`.
  - No word transfers in the arbitration cycle.
- **State `LOCKED`:**
  - `req_ready[owner] = fifo_can_write`; every other `req_ready` bit is 0.
  - `fifo_write = req_valid[owner] && fifo_can_write`.
  - `fifo_write_data` = the owner's data lane.
  - These three are combinational from the inputs: zero-cycle pass-through.
  - A transfer with `req_last[owner]` set returns the block to `IDLE` and sets `last_grant <= owner`.
- **FIFO full mid-packet:** stall with the grant held. No words are dropped and no other requester is served.
- **Owner drops `req_valid` mid-packet:** the grant is held indefinitely. There is no timeout; producers must keep packets contiguous.
- **Single-word packet** (`req_last` on the first word): the packet occupies one `LOCKED` cycle plus its arbitration cycle.
- **Owner withdraws `req_valid` in the arbitration cycle:** the grant is kept anyway and waits in `LOCKED`.
- **`req_last` on a word that does not transfer:** ignored; only accepted words count.
- **Reset (`rst == 0` at a rising edge):**
  - State goes to `IDLE`, `owner = 0`, `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - Outputs the following cycle: `req_ready = 0`, `fifo_write = 0`, `fifo_write_data = 0`, `grant_id = 0`, `busy = 0`.
  - Reset mid-packet truncates the packet. Words already written stay in the FIFO; the FIFO has its own reset.

## Timing
- **Request to first transfer:** 1 cycle, from `req_valid` rising in `IDLE` to the first possible transfer.
- **Throughput in `LOCKED`:** 1 word per cycle while `fifo_can_write` is high.
- **Packet gap:** each packet costs exactly one idle cycle (`IDLE`) between its last word and the next packet's first word.
- **`grant_id` and `busy`:** registered; they change on the edge that enters or leaves `LOCKED`.
- **Combinational paths:**
  - `fifo_can_write` → `req_ready` / `fifo_write`.
  - `req_valid` / `req_data` → `fifo_write` / `fifo_write_data`.
  - There is no path from `req_ready` back to `req_valid` inside the block.
- **Fairness:** after granting i, every other requester that is continuously valid is served before i is served again. The worst-case wait is NUM_REQ-1 packets.

## Structure
- No shared package. State encodings `IDLE`/`LOCKED` are localparams in this module.
- One sub-module: `rr_pick`. It is purely combinational:
  - inputs: `req` mask, `last` index;
  - outputs: `found`, `idx`;
  - parameter: `NUM_REQ`;
  - reusable by later arbiters.
- Everything else (state register, owner/last_grant registers, output muxing) stays in `fifo_write_arbiter`.

## Test plan
- **Reset then single request:** hold reset, release; `req_valid=4'b0100`, 3-word packet 0x11, 0x22, 0x33 with last on 0x33, `fifo_can_write=1` throughout.
  - Expect `grant_id=2` and `busy=1` one cycle later.
  - Expect three consecutive writes of 0x11, 0x22, 0x33.
  - Expect `IDLE` on the next cycle.
- **All four requesting continuously**, 1-word packets.
  - Grant order 0,1,2,3,0.
  - Each grant is followed by one write and one idle cycle.
- **Requesters 1 and 3 both send 2-word packets.**
  - FIFO content is the 1 packet, then the 3 packet, with no interleaving.
- **FIFO full mid-packet:** `fifo_can_write=0` for 3 cycles after word 1 of 4.
  - `req_ready[owner]=0` and `fifo_write=0` for those cycles.
  - Others stay blocked; the remaining words follow in order.
- **Reset asserted mid-packet** after 2 of 5 words.
  - Next cycle: all outputs 0, state `IDLE`.
  - After release, requester 0 wins first if valid.
- **Owner gaps `req_valid` for 2 cycles mid-packet** while requester 0 is valid.
  - No write and no grant change; the packet completes afterwards.

Source files
------------

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set bit of req scanning upward from last+1,
// wrapping modulo NUM_REQ. Purely combinational so later arbiters can reuse it.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    // cand[k] is the index examined at scan distance k+1 from last
    logic [ID_W-1:0] cand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = ID_W'((int'(last) + gi + 1) % NUM_REQ);
        end
    endgenerate

    // Walk from farthest to nearest so the nearest valid candidate wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-based round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// The owner keeps the port from its first word until a word flagged last is accepted.
module fifo_write_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int BIT_WIDTH = 8,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         fifo_write,
    output logic [BIT_WIDTH-1:0]         fifo_write_data,
    input  logic                         fifo_can_write,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy
);

    localparam logic IDLE   = 1'b0;
    localparam logic LOCKED = 1'b1;

    logic            state_reg, state_next;
    logic [ID_W-1:0] owner_reg, owner_next;
    logic [ID_W-1:0] last_grant_reg, last_grant_next;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;

    logic [BIT_WIDTH-1:0] lane [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane[gi] = req_data[gi*BIT_WIDTH +: BIT_WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .last  (last_grant_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        req_ready       = '0;
        fifo_write      = 1'b0;
        fifo_write_data = '0;
        case (state_reg)
            IDLE: begin
                // Arbitration cycle: nothing transfers, the winner is only registered
                if (pick_found) begin
                    owner_next = pick_idx;
                    state_next = LOCKED;
                end
            end
            default: begin
                req_ready[owner_reg] = fifo_can_write;
                fifo_write           = req_valid[owner_reg] && fifo_can_write;
                fifo_write_data      = lane[owner_reg];
                if (fifo_write && req_last[owner_reg]) begin
                    state_next      = IDLE;
                    last_grant_next = owner_reg;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
        end
    end

    assign busy     = (state_reg == LOCKED);
    assign grant_id = (state_reg == LOCKED) ? owner_reg : '0;

endmodule
